// File: rtl/produto_escalar_stream.sv
// -----------------------------------------------------------------------------
// produto_escalar_stream
// Streaming dot-product engine. A run length (1..MAX_LEN), operand signedness
// and an accumulate-onto-previous-result flag are captured together with
// start. The engine then performs one multiply-accumulate per accepted input
// beat and presents the final sum on a valid/ready result handshake.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start, len          : begin an operation with len element pairs (IDLE only)
//   signed_mode         : 1 = operands are two's complement, 0 = unsigned
//   acc_mode            : 1 = start from the previous result, 0 = start from 0
//   in_valid/in_ready   : input pair handshake, in_a / in_b are the elements
//   out_valid/out_ready : result handshake, result is the dot product
//   busy                : operation in progress (RUN or DONE)
//   len_err             : one-cycle pulse when start is seen with a bad len
// -----------------------------------------------------------------------------
module produto_escalar_stream #(
    parameter  int DATA_W  = 32,
    parameter  int MAX_LEN = 64,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int ACC_W   = 2 * DATA_W + $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              signed_mode,
    input  logic              acc_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PROD_W = 2 * DATA_W;

    // Product of two operands, widened to the accumulator width. Operands are
    // extended to PROD_W before multiplying, so keeping only the low PROD_W
    // bits gives the exact two's complement (or unsigned) product; the product
    // is then extended to ACC_W with the same signedness rule.
    function automatic logic [ACC_W-1:0] mac_term(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic [PROD_W-1:0] ea;
        logic [PROD_W-1:0] eb;
        logic [PROD_W-1:0] p;
        ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
        eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
        p  = ea * eb;
        return {{(ACC_W - PROD_W){sgn & p[PROD_W-1]}}, p};
    endfunction

    state_t             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [LEN_W-1:0]   cnt_q,       cnt_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic               sgn_q,       sgn_d;
    logic [ACC_W-1:0]   result_q,    result_d;
    logic               len_err_q,   len_err_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic               len_ok_s;
    logic               last_beat_s;
    logic [ACC_W-1:0]   sum_s;

    assign len_ok_s    = (len != {LEN_W{1'b0}}) && (len <= LEN_W'(MAX_LEN));
    assign last_beat_s = (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign sum_s       = acc_q + mac_term(in_a, in_b, sgn_q);

    // Next-state, datapath and output decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sgn_d       = sgn_q;
        result_d    = result_q;
        len_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        len_d   = len;
                        sgn_d   = signed_mode;
                        acc_d   = acc_mode ? result_q : {ACC_W{1'b0}};
                        cnt_d   = {LEN_W{1'b0}};
                        state_d = ST_RUN;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_valid && in_ready_q) begin
                    acc_d = sum_s;
                    cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    if (last_beat_s) begin
                        result_d = sum_s;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are decoded from the next state so that the
        // flops below present them in the same cycle the state is entered.
        in_ready_d  = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {LEN_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            sgn_q       <= 1'b0;
            result_q    <= {ACC_W{1'b0}};
            len_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sgn_q       <= sgn_d;
            result_q    <= result_d;
            len_err_q   <= len_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign len_err   = len_err_q;
    assign result    = result_q;

endmodule
